paralelo_serial: RTL and testbench

- Transmit-side parallel-to-serial converter. It sits directly upstream of the serial-to-parallel receiver and drives that receiver's data_in.
- Accepts bytes through a valid/ready handshake and shifts them out MSB-first, one bit per clk_32f cycle.
- Fills every byte slot that has no data with the COM symbol (0xBC).
- After reset, sends a burst of N_COM COM symbols so the receiver can lock before any data is accepted.

---
 rtl/paralelo_serial.sv | 104 ++++++++++
 tb/tb_paralelo_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial.sv
// rtl/paralelo_serial.sv - parallel-to-serial transmitter with COM fill and startup COM burst
// Bytes enter through a one-deep buffer and leave MSB-first, one bit per clk_32f cycle.
module paralelo_serial #(
    parameter int          N_COM = 4,
    parameter logic [7:0]  COM   = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       data_out,
    output logic       active,
    output logic       data_sent
);

    typedef enum logic {
        ST_INIT,
        ST_ACTIVE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_sent_q, com_sent_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       active_q, active_d;
    logic       data_sent_q, data_sent_d;

    logic boundary;
    logic accept;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd7;
            com_sent_q  <= 4'd0;
            buf_q       <= 8'h00;
            buf_full_q  <= 1'b0;
            active_q    <= 1'b0;
            data_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            com_sent_q  <= com_sent_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            active_q    <= active_d;
            data_sent_q <= data_sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        com_sent_d  = com_sent_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        active_d    = active_q;
        data_sent_d = 1'b0;

        boundary = (bit_cnt_q == 3'd7);
        ready    = (state_q == ST_ACTIVE) && (!buf_full_q || boundary);
        accept   = valid_in && ready;

        if (boundary) begin
            bit_cnt_d = 3'd0;
            if (state_q == ST_ACTIVE && buf_full_q) begin
                shift_d     = buf_q;
                buf_full_d  = 1'b0;
                data_sent_d = 1'b1;
            end else begin
                shift_d = COM;
            end
            // The burst is complete once N_COM bytes have fully left the shifter.
            if (state_q == ST_INIT) begin
                if (com_sent_q == 4'(N_COM)) begin
                    state_d  = ST_ACTIVE;
                    active_d = 1'b1;
                end else begin
                    com_sent_d = com_sent_q + 4'd1;
                end
            end
        end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        // A write after the drain above keeps buf_full set when both happen together.
        if (accept) begin
            buf_d      = data_in;
            buf_full_d = 1'b1;
        end
    end

    assign data_out  = shift_q[7];
    assign active    = active_q;
    assign data_sent = data_sent_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// tb/tb_paralelo_serial.sv - self-checking bench for paralelo_serial
module tb_paralelo_serial;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic       data_out;
    logic       active;
    logic       data_sent;

    paralelo_serial #(.N_COM(4), .COM(8'hBC)) dut (
        .clk_32f  (clk),
        .reset    (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .data_out (data_out),
        .active   (active),
        .data_sent(data_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       vin;
        logic [7:0] din;
        logic       e_do;
        logic       e_rdy;
        logic       e_act;
        logic       e_ds;
    } vec_t;

    vec_t vt[56];

    logic [7:0] feed_q[$];
    int         accepted;
    int         rdy_low;
    logic       log_do[256];
    logic       log_ds[256];
    logic       log_rdy[256];

    logic       rx_en = 1'b0;
    logic [7:0] rx_win;
    logic       rx_locked;
    int         rx_cnt;
    int         rx_com;
    logic       rx_active;
    logic [7:0] rx_q[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int n);
        for (int e = 0; e < n; e++) begin
            valid_in = vt[e].vin;
            data_in  = vt[e].din;
            tick();
            chk("vec_data_out", e, 32'(data_out), 32'(vt[e].e_do));
            chk("vec_ready", e, 32'(ready), 32'(vt[e].e_rdy));
            chk("vec_active", e, 32'(active), 32'(vt[e].e_act));
            chk("vec_data_sent", e, 32'(data_sent), 32'(vt[e].e_ds));
        end
        valid_in = 1'b0;
    endtask

    task automatic feed(input int ncyc);
        logic rdy;
        accepted = 0;
        rdy_low  = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (accepted < feed_q.size()) begin
                valid_in = 1'b1;
                data_in  = feed_q[accepted];
            end else begin
                valid_in = 1'b0;
            end
            rdy = ready;
            if (valid_in && !rdy) rdy_low++;
            tick();
            if (valid_in && rdy) accepted++;
            log_do[c]  = data_out;
            log_ds[c]  = data_sent;
            log_rdy[c] = ready;
        end
        valid_in = 1'b0;
    endtask

    function automatic logic [7:0] byte_at(input int s);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[7-b] = log_do[s+b];
        return r;
    endfunction

    function automatic int count_ds(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) if (log_ds[c]) k++;
        return k;
    endfunction

    task automatic hold_reset();
        valid_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Bench-side serial-to-parallel receiver: locks on COM, goes active after 4 COMs.
    always @(negedge clk) begin
        if (!rx_en) begin
            rx_win    = 8'h00;
            rx_locked = 1'b0;
            rx_cnt    = 0;
            rx_com    = 0;
            rx_active = 1'b0;
        end else begin
            rx_win = {rx_win[6:0], data_out};
            if (!rx_locked) begin
                if (rx_win == COM) begin
                    rx_locked = 1'b1;
                    rx_cnt    = 0;
                    rx_com    = 1;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    if (rx_win == COM) begin
                        if (rx_com < 4) rx_com++;
                    end else if (rx_active) begin
                        rx_q.push_back(rx_win);
                    end
                    if (rx_com == 4) rx_active = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [7:0] com_v;
        logic [7:0] a5_v;
        int         f;
        com_v = COM;
        a5_v  = 8'hA5;

        for (int e = 0; e < 56; e++) begin
            int b;
            b = 7 - (e % 8);
            vt[e].vin   = 1'b0;
            vt[e].din   = 8'h00;
            vt[e].e_act = (e >= 32);
            vt[e].e_rdy = (e >= 32) && !(e >= 33 && e <= 38);
            vt[e].e_ds  = 1'b0;
            vt[e].e_do  = (e >= 40 && e <= 47) ? a5_v[b] : com_v[b];
        end
        vt[33].vin  = 1'b1;
        vt[33].din  = 8'hA5;
        vt[40].e_ds = 1'b1;

        // Reset state, then startup burst and a single byte
        valid_in = 1'b0;
        data_in  = 8'h00;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 0, 32'(data_out), 32'h0);
        chk("rst_ready", 0, 32'(ready), 32'h0);
        chk("rst_active", 0, 32'(active), 32'h0);
        chk("rst_data_sent", 0, 32'(data_sent), 32'h0);
        rst = 1'b0;
        run_vec(56);

        // Back-to-back stream
        feed_q = '{8'h01, 8'h02, 8'h03, 8'hFF};
        feed(48);
        chk("b2b_accepted", 0, 32'(accepted), 32'd4);
        chk("b2b_ready_dropped", 0, 32'(rdy_low > 0), 32'h1);
        f = -1;
        for (int c = 0; c < 48; c++) if (log_ds[c] && f < 0) f = c;
        chk("b2b_first_sent", 0, 32'(f), 32'd8);
        if (f >= 0 && f <= 8) begin
            for (int k = 0; k < 4; k++) begin
                chk("b2b_byte", k, 32'(byte_at(f + 8*k)), 32'(feed_q[k]));
                chk("b2b_strobe", k, 32'(log_ds[f + 8*k]), 32'h1);
            end
            chk("b2b_com_after", 0, 32'(byte_at(f + 32)), 32'(COM));
        end
        chk("b2b_strobe_count", 0, 32'(count_ds(48)), 32'd4);

        // Simultaneous drain and fill
        feed_q = '{8'h11, 8'h22};
        feed(32);
        chk("df_accepted", 0, 32'(accepted), 32'd2);
        chk("df_sent_11", 0, 32'(log_ds[8]), 32'h1);
        chk("df_buf_full_kept", 0, 32'(log_rdy[8]), 32'h0);
        chk("df_byte_11", 0, 32'(byte_at(8)), 32'h11);
        chk("df_sent_22", 0, 32'(log_ds[16]), 32'h1);
        chk("df_byte_22", 0, 32'(byte_at(16)), 32'h22);
        chk("df_com_after", 0, 32'(byte_at(24)), 32'(COM));
        chk("df_strobe_count", 0, 32'(count_ds(32)), 32'd2);

        // Reset mid-byte with a byte buffered
        feed_q = '{8'h5A, 8'h33};
        feed(10);
        chk("mid_sent_5a", 0, 32'(log_ds[8]), 32'h1);
        chk("mid_accepted", 0, 32'(accepted), 32'd2);
        chk("mid_pre_bit", 0, 32'(data_out), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data_out", 0, 32'(data_out), 32'h0);
        chk("mid_rst_active", 0, 32'(active), 32'h0);
        chk("mid_rst_ready", 0, 32'(ready), 32'h0);
        chk("mid_rst_data_sent", 0, 32'(data_sent), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(33);
        feed_q = {};
        feed(48);
        chk("mid_no_33", 0, 32'(count_ds(48)), 32'd0);
        for (int k = 0; k < 5; k++) chk("mid_com_fill", k, 32'(byte_at(7 + 8*k)), 32'(COM));

        // Receiver loopback
        hold_reset();
        rx_en = 1'b1;
        feed_q = {};
        for (int k = 0; k < 16; k++) feed_q.push_back(8'(8'h10 + k));
        feed(200);
        chk("lb_accepted", 0, 32'(accepted), 32'd16);
        chk("lb_rx_active", 0, 32'(rx_active), 32'h1);
        chk("lb_rx_count", 0, 32'(rx_q.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < rx_q.size()) chk("lb_rx_byte", k, 32'(rx_q[k]), 32'(feed_q[k]));
            else chk("lb_rx_byte_missing", k, 32'h0, 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
